// File: rtl/muldiv_pkg.sv
`default_nettype none
//============================================================================
// Module : muldiv_pkg
// Desc   : Op codes, FSM state type and decode helpers for muldiv_seq.
// Rev    : 1.0
//============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] C_OP_MUL    = 6'b100110;
    localparam logic [5:0] C_OP_MULH   = 6'b100111;
    localparam logic [5:0] C_OP_MULHSU = 6'b101000;
    localparam logic [5:0] C_OP_MULHU  = 6'b101001;
    localparam logic [5:0] C_OP_DIV    = 6'b101010;
    localparam logic [5:0] C_OP_DIVU   = 6'b101011;
    localparam logic [5:0] C_OP_REM    = 6'b101100;
    localparam logic [5:0] C_OP_REMU   = 6'b101101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_mul(input logic [5:0] op);
        return op inside {C_OP_MUL, C_OP_MULH, C_OP_MULHSU, C_OP_MULHU};
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return op inside {C_OP_DIV, C_OP_DIVU, C_OP_REM, C_OP_REMU};
    endfunction

    function automatic logic is_rem(input logic [5:0] op);
        return op inside {C_OP_REM, C_OP_REMU};
    endfunction

    function automatic logic is_signed_a(input logic [5:0] op);
        return op inside {C_OP_MUL, C_OP_MULH, C_OP_MULHSU, C_OP_DIV, C_OP_REM};
    endfunction

    function automatic logic is_signed_b(input logic [5:0] op);
        return op inside {C_OP_MUL, C_OP_MULH, C_OP_DIV, C_OP_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
//============================================================================
// Module : muldiv_seq_if
// Desc   : Request/response bundle between the decoder and muldiv_seq.
// Rev    : 1.0
//============================================================================
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            start;
    logic            flush;
    logic [5:0]      aluSelect;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, aluSelect, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, aluSelect, rs1, rs2,
        output busy, done, result
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_iter_dp.sv
`default_nettype none
//============================================================================
// Module : muldiv_iter_dp
// Desc   : Shared 64-bit accumulator with radix-2 shift-add / restoring step.
// Rev    : 1.0
//============================================================================
module muldiv_iter_dp
    import muldiv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            load,
    input  wire logic            step,
    input  wire logic            mul_sel,
    input  wire logic [XLEN-1:0] op_a,
    input  wire logic [XLEN-1:0] op_b,
    output logic      [XLEN-1:0] hi,
    output logic      [XLEN-1:0] lo
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;

    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;

    // Multiply: hi accumulates the multiplicand while the multiplier shifts out of lo.
    // Divide: lo shifts the dividend into hi and collects quotient bits at the bottom.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
        w_diff     = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_b};
        w_ge       = (w_diff[XLEN+1:XLEN] == 2'b00);
        w_div_next = w_ge ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                          : {r_acc[2*XLEN-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_b   <= '0;
        end else if (load) begin
            r_acc <= {{XLEN{1'b0}}, op_a};
            r_b   <= op_b;
        end else if (step) begin
            r_acc <= mul_sel ? w_mul_next : w_div_next;
        end
    end

    assign hi = r_acc[2*XLEN-1:XLEN];
    assign lo = r_acc[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
//============================================================================
// Module : muldiv_seq
// Desc   : Iterative RV32M multiply/divide unit with fast path and flush.
// Rev    : 1.0
//============================================================================
module muldiv_seq
    import muldiv_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    muldiv_seq_if.slave bus
);

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_op;
    logic            r_neg;
    logic [4:0]      r_count;
    logic [XLEN-1:0] r_result;

    logic            w_accept, w_load, w_step, w_fix;
    logic            w_neg_a, w_neg_b, w_neg;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_valid, w_div_zero, w_ovf, w_fast;
    logic [XLEN-1:0] w_fast_val;
    logic [XLEN-1:0] w_hi, w_lo;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0] w_word, w_fix_val;

    // Operand conditioning and fast-path decode on the incoming request.
    always_comb begin
        w_neg_a    = is_signed_a(bus.aluSelect) & bus.rs1[XLEN-1];
        w_neg_b    = is_signed_b(bus.aluSelect) & bus.rs2[XLEN-1];
        w_mag_a    = w_neg_a ? (~bus.rs1 + 1'b1) : bus.rs1;
        w_mag_b    = w_neg_b ? (~bus.rs2 + 1'b1) : bus.rs2;
        w_neg      = is_rem(bus.aluSelect) ? w_neg_a : (w_neg_a ^ w_neg_b);
        w_valid    = is_mul(bus.aluSelect) | is_div(bus.aluSelect);
        w_div_zero = is_div(bus.aluSelect) & (bus.rs2 == '0);
        w_ovf      = ((bus.aluSelect == C_OP_DIV) | (bus.aluSelect == C_OP_REM))
                   & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2 == '1);
        w_fast     = ~w_valid | w_div_zero | w_ovf;
        w_fast_val = '0;
        if (w_valid && w_div_zero) begin
            w_fast_val = is_rem(bus.aluSelect) ? bus.rs1 : '1;
        end else if (w_valid && w_ovf) begin
            w_fast_val = is_rem(bus.aluSelect) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_fix    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_accept = 1'b1;
                    if (w_fast) begin
                        w_next = DONE;
                    end else begin
                        w_next = CALC;
                        w_load = 1'b1;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    w_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_count == '0) w_next = FIX;
                end
            end
            FIX: begin
                if (bus.flush) begin
                    w_next = IDLE;
                end else begin
                    w_fix  = 1'b1;
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Sign fixup: multiply negates the full product, divide negates the chosen word.
    always_comb begin
        w_prod     = {w_hi, w_lo};
        w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
        w_word     = is_rem(r_op) ? w_hi : w_lo;
        if (is_mul(r_op)) begin
            w_fix_val = (r_op == C_OP_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        end else begin
            w_fix_val = r_neg ? (~w_word + 1'b1) : w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_op    <= bus.aluSelect;
                r_neg   <= w_neg;
                r_count <= 5'd31;
            end else if (w_step) begin
                r_count <= r_count - 5'd1;
            end
            if (w_accept && w_fast) begin
                r_result <= w_fast_val;
            end else if (w_fix) begin
                r_result <= w_fix_val;
            end
        end
    end

    muldiv_iter_dp u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .step    (w_step),
        .mul_sel (is_mul(r_op)),
        .op_a    (w_mag_a),
        .op_b    (w_mag_b),
        .hi      (w_hi),
        .lo      (w_lo)
    );

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire
